// File: rtl/fetch_unit.sv
// Instruction fetch front end: drives a synchronous-read ICache one word
// address per cycle and buffers returned words in a 2-entry {pc,instr}
// skid FIFO so decode back-pressure never drops an in-flight response.
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clka,
    input  logic        rsta,
    output logic [15:0] icache_addr,
    output logic        icache_we,
    output logic [31:0] icache_din,
    input  logic [31:0] icache_dout,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [15:0] if_pc
);

    logic [15:0] req_pc_q,  req_pc_d;
    logic [15:0] pc_prev_q, pc_prev_d;
    logic        inflight_q, inflight_d;
    logic [1:0]  count_q,   count_d;
    logic [15:0] pc0_q,  pc0_d,  pc1_q,  pc1_d;
    logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;

    logic        pop;
    logic        push;
    logic        issue;
    logic [2:0]  occ;

    // The ICache port is read-only from fetch.
    assign icache_addr = req_pc_q;
    assign icache_we   = 1'b0;
    assign icache_din  = 32'h0000_0000;

    // Head of the FIFO is always entry 0.
    assign if_valid = (count_q != 2'd0);
    assign if_instr = ins0_q;
    assign if_pc    = pc0_q;

    // Only issue when the response is guaranteed a FIFO slot next edge.
    assign pop   = if_valid & id_ready;
    assign push  = inflight_q;
    assign occ   = {1'b0, count_q} + {2'b00, inflight_q};
    assign issue = (occ < (3'd2 + {2'b00, pop}));

    // Next-state: redirect flushes everything; otherwise issue, push, pop.
    always_comb begin
        req_pc_d   = req_pc_q;
        pc_prev_d  = pc_prev_q;
        inflight_d = inflight_q;
        count_d    = count_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;
        ins0_d     = ins0_q;
        ins1_d     = ins1_q;
        if (redirect) begin
            // The response arriving this cycle belongs to the old path.
            req_pc_d   = redirect_pc;
            inflight_d = 1'b0;
            count_d    = 2'd0;
        end else begin
            if (issue) begin
                req_pc_d   = req_pc_q + 16'd1;
                pc_prev_d  = req_pc_q;
                inflight_d = 1'b1;
            end else begin
                inflight_d = 1'b0;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_d  = pc_prev_q;
                        ins0_d = icache_dout;
                    end else begin
                        pc1_d  = pc_prev_q;
                        ins1_d = icache_dout;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    pc0_d   = pc1_q;
                    ins0_d  = ins1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        pc0_d  = pc_prev_q;
                        ins0_d = icache_dout;
                    end else begin
                        pc0_d  = pc1_q;
                        ins0_d = ins1_q;
                        pc1_d  = pc_prev_q;
                        ins1_d = icache_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    // State update; reset also clears the head so if_instr/if_pc read zero.
    always_ff @(posedge clka) begin
        if (rsta) begin
            req_pc_q   <= RESET_PC;
            pc_prev_q  <= 16'h0000;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            pc0_q      <= 16'h0000;
            pc1_q      <= 16'h0000;
            ins0_q     <= 32'h0000_0000;
            ins1_q     <= 32'h0000_0000;
        end else begin
            req_pc_q   <= req_pc_d;
            pc_prev_q  <= pc_prev_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            ins0_q     <= ins0_d;
            ins1_q     <= ins1_d;
        end
    end

    // A push into a full FIFO without a pop would lose a word.
    always @(posedge clka) begin
        if (!rsta && !redirect)
            assert (!(push && !pop && count_q == 2'd2));
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirects, reset, wrap.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rsta;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        id_ready;

    logic [15:0] addr1;
    logic        we1;
    logic [31:0] din1;
    logic [31:0] dout1;
    logic        vld1;
    logic [31:0] instr1;
    logic [15:0] pc1;

    logic [15:0] addr2;
    logic        we2;
    logic [31:0] din2;
    logic [31:0] dout2;
    logic        vld2;
    logic [31:0] instr2;
    logic [15:0] pc2;
    logic        redirect2 = 1'b0;
    logic [15:0] redirect_pc2 = 16'h0000;
    logic        ready2 = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(16'h0000)) dut (
        .clka(clk), .rsta(rsta),
        .icache_addr(addr1), .icache_we(we1), .icache_din(din1), .icache_dout(dout1),
        .redirect(redirect), .redirect_pc(redirect_pc), .id_ready(id_ready),
        .if_valid(vld1), .if_instr(instr1), .if_pc(pc1)
    );

    fetch_unit #(.RESET_PC(16'hFFFE)) dut_wrap (
        .clka(clk), .rsta(rsta),
        .icache_addr(addr2), .icache_we(we2), .icache_din(din2), .icache_dout(dout2),
        .redirect(redirect2), .redirect_pc(redirect_pc2), .id_ready(ready2),
        .if_valid(vld2), .if_instr(instr2), .if_pc(pc2)
    );

    // ICache models: mem[i] = 32'h100 + i, one-cycle read latency.
    always @(posedge clk) dout1 <= 32'h100 + {16'h0000, addr1};
    always @(posedge clk) dout2 <= 32'h100 + {16'h0000, addr2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic [15:0] pc);
        chk({tag, "_vld"}, {31'd0, vld1}, 32'd1);
        chk({tag, "_pc"}, {16'd0, pc1}, {16'd0, pc});
        chk({tag, "_ins"}, instr1, 32'h100 + {16'd0, pc});
    endtask

    initial begin
        rsta = 1'b1; redirect = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b1;
        tick(); tick();
        // Reset state
        chk("rst_vld", {31'd0, vld1}, 32'd0);
        chk("rst_pc", {16'd0, pc1}, 32'd0);
        chk("rst_ins", instr1, 32'd0);
        chk("rst_addr", {16'd0, addr1}, 32'd0);
        chk("rst_we", {31'd0, we1}, 32'd0);
        chk("rst_din", din1, 32'd0);
        chk("rst_addr2", {16'd0, addr2}, 32'h0000_FFFE);
        rsta = 1'b0;
        tick();
        chk("lat1_vld", {31'd0, vld1}, 32'd0);
        tick();
        // Streaming, one per cycle; wrap instance alongside
        for (int i = 0; i < 5; i++) begin
            chk_out("stream", 16'(i));
            if (i < 4) begin
                chk("wrap_vld", {31'd0, vld2}, 32'd1);
                chk("wrap_pc", {16'd0, pc2}, {16'd0, 16'hFFFE + 16'(i)});
                chk("wrap_ins", instr2, 32'h100 + {16'd0, 16'hFFFE + 16'(i)});
            end
            tick();
        end
        // Stall at pc 5 for three edges
        chk_out("stall0", 16'd5);
        id_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_out("stall", 16'd5);
        end
        id_ready = 1'b1;
        for (int i = 6; i <= 8; i++) begin
            tick();
            chk_out("resume", 16'(i));
        end
        // Fill FIFO, then redirect to 0x40
        id_ready = 1'b0;
        tick(); tick(); tick();
        chk_out("fill", 16'd8);
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        chk("redir_vld0", {31'd0, vld1}, 32'd0);
        redirect = 1'b0; id_ready = 1'b1;
        tick();
        chk("redir_vld1", {31'd0, vld1}, 32'd0);
        tick();
        chk_out("redir_first", 16'h0040);
        tick();
        chk_out("redir_next", 16'h0041);
        tick();
        chk_out("redir_pop", 16'h0042);
        // Redirect together with a pop of 0x42
        redirect = 1'b1; redirect_pc = 16'h0080;
        tick();
        chk("rpop_vld0", {31'd0, vld1}, 32'd0);
        redirect = 1'b0;
        tick();
        chk("rpop_vld1", {31'd0, vld1}, 32'd0);
        tick();
        chk_out("rpop_first", 16'h0080);
        // Reset beats redirect with a full FIFO
        id_ready = 1'b0;
        tick(); tick(); tick();
        rsta = 1'b1; redirect = 1'b1; redirect_pc = 16'h0055;
        tick();
        chk("rr_vld", {31'd0, vld1}, 32'd0);
        chk("rr_addr", {16'd0, addr1}, 32'd0);
        chk("rr_pc", {16'd0, pc1}, 32'd0);
        chk("rr_ins", instr1, 32'd0);
        rsta = 1'b0; redirect = 1'b0; id_ready = 1'b1;
        tick();
        chk("rr_lat_vld", {31'd0, vld1}, 32'd0);
        tick();
        chk_out("rr_first", 16'h0000);
        tick();
        chk_out("rr_next", 16'h0001);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
